// File: rtl/hack_pkg.sv
// Shared Hack ALU definitions: data width, op-word bit positions, named ops
// and the arbiter state encoding.
package hack_pkg;

  localparam int unsigned HACK_W = 16;
  localparam int unsigned OP_W   = 6;

  // Bit positions inside the {zx,nx,zy,ny,f,no} control word
  localparam int unsigned OP_ZX = 5;
  localparam int unsigned OP_NX = 4;
  localparam int unsigned OP_ZY = 3;
  localparam int unsigned OP_NY = 2;
  localparam int unsigned OP_F  = 1;
  localparam int unsigned OP_NO = 0;

  localparam logic [OP_W-1:0] OP_AND    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADD    = 6'b000010;
  localparam logic [OP_W-1:0] OP_SUB_XY = 6'b010011;
  localparam logic [OP_W-1:0] OP_ZERO   = 6'b101010;
  localparam logic [OP_W-1:0] OP_NEG1   = 6'b111010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/negate of each operand, AND or ADD,
// optional negate of the result, plus zero and negative flags.
module hack_alu
  import hack_pkg::*;
#(
  parameter int unsigned N = HACK_W
) (
  input  logic [N-1:0]    x,
  input  logic [N-1:0]    y,
  input  logic [OP_W-1:0] op,
  output logic [N-1:0]    out,
  output logic            zr,
  output logic            ng
);

  logic [N-1:0] w_x_z;
  logic [N-1:0] w_x;
  logic [N-1:0] w_y_z;
  logic [N-1:0] w_y;
  logic [N-1:0] w_f;

  assign w_x_z = op[OP_ZX] ? '0 : x;
  assign w_x   = op[OP_NX] ? ~w_x_z : w_x_z;
  assign w_y_z = op[OP_ZY] ? '0 : y;
  assign w_y   = op[OP_NY] ? ~w_y_z : w_y_z;

  // Sum wraps modulo 2^N; the carry out is intentionally dropped
  assign w_f   = op[OP_F] ? (w_x + w_y) : (w_x & w_y);
  assign out   = op[OP_NO] ? ~w_f : w_f;
  assign zr    = (out == '0);
  assign ng    = out[N-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one hack_alu between two requesters; the
// registered result is returned over a valid/ready response channel.
module alu_arbiter
  import hack_pkg::*;
#(
  parameter int unsigned N = HACK_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [N-1:0]    req0_x,
  input  logic [N-1:0]    req0_y,
  input  logic [OP_W-1:0] req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [N-1:0]    req1_x,
  input  logic [N-1:0]    req1_y,
  input  logic [OP_W-1:0] req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_out,
  output logic            rsp_zr,
  output logic            rsp_ng,
  output logic            rsp_id
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic            r_last;
  logic [N-1:0]    r_x;
  logic [N-1:0]    r_y;
  logic [OP_W-1:0] r_op;
  logic            r_id;

  logic            r_rsp_valid;
  logic [N-1:0]    r_rsp_out;
  logic            r_rsp_zr;
  logic            r_rsp_ng;
  logic            r_rsp_id;

  logic            w_gnt0;
  logic            w_gnt1;
  logic [N-1:0]    w_alu_out;
  logic            w_alu_zr;
  logic            w_alu_ng;

  hack_alu #(.N(N)) u_alu (
    .x   (r_x),
    .y   (r_y),
    .op  (r_op),
    .out (w_alu_out),
    .zr  (w_alu_zr),
    .ng  (w_alu_ng)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant only in IDLE; on a tie the requester that did not win last time goes
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || r_last)) begin
          w_gnt0 = 1'b1;
        end else if (req1_valid) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign req0_ready = w_gnt0 & ~reset;
  assign req1_ready = w_gnt1 & ~reset;

  // Operand capture on grant, result capture at the end of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_x         <= '0;
      r_y         <= '0;
      r_op        <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_zr    <= 1'b0;
      r_rsp_ng    <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else begin
      r_rsp_valid <= (w_next == ST_RESP);
      if (w_gnt0) begin
        r_x    <= req0_x;
        r_y    <= req0_y;
        r_op   <= req0_op;
        r_id   <= 1'b0;
        r_last <= 1'b0;
      end else if (w_gnt1) begin
        r_x    <= req1_x;
        r_y    <= req1_y;
        r_op   <= req1_op;
        r_id   <= 1'b1;
        r_last <= 1'b1;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_out <= w_alu_out;
        r_rsp_zr  <= w_alu_zr;
        r_rsp_ng  <= w_alu_ng;
        r_rsp_id  <= r_id;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_out   = r_rsp_out;
  assign rsp_zr    = r_rsp_zr;
  assign rsp_ng    = r_rsp_ng;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// reset/backpressure/fairness sequences and randomized traffic vs a model.
module tb_alu_arbiter;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic [5:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_out;
  logic        rsp_zr, rsp_ng, rsp_id;

  alu_arbiter #(.N(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_zr     (rsp_zr),
    .rsp_ng     (rsp_ng),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rq;
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  op;
    logic [15:0] eo;
    bit          ezr;
    bit          eng;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one outstanding op, timed by cycles since acceptance
  bit          m_busy;
  bit          m_last;
  bit          m_id;
  int          m_age;
  logic [15:0] m_out;

  int          g_id[$];
  int          g_cyc[$];
  logic [15:0] r_out_q[$];
  bit          r_id_q[$];
  bit          r_zr_q[$];
  bit          r_ng_q[$];
  int          r_cyc_q[$];

  function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] op);
    int unsigned a, b, o;
    a = op[5] ? 0 : 32'(x);
    if (op[4]) a = 65535 - a;
    b = op[3] ? 0 : 32'(y);
    if (op[2]) b = 65535 - b;
    o = op[1] ? (a + b) % 65536 : (a & b);
    if (op[0]) o = 65535 - o;
    return 16'(o);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_age  = 0;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete();
    r_out_q.delete(); r_id_q.delete(); r_zr_q.delete(); r_ng_q.delete(); r_cyc_q.delete();
  endtask

  // One clock: check DUT against the model on the falling edge, then advance
  task automatic step();
    bit e0, e1;
    logic [15:0] yo;
    @(negedge clk);
    cyc++;
    chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
    if (m_busy) m_age++;
    if (!m_busy) begin
      e0 = req0_valid && (!req1_valid || m_last);
      e1 = req1_valid && !e0;
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      if (e0 || e1) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = e1;
        m_last = e1;
        m_out  = e1 ? alu_ref(req1_x, req1_y, req1_op) : alu_ref(req0_x, req0_y, req0_op);
      end
    end else begin
      chk("req0_ready_busy", 32'(req0_ready), 32'd0);
      chk("req1_ready_busy", 32'(req1_ready), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_age >= 2));
      if (m_age >= 2) begin
        yo = m_out;
        chk("rsp_out", 32'(rsp_out), 32'(yo));
        chk("rsp_zr", 32'(rsp_zr), 32'(yo == 16'd0));
        chk("rsp_ng", 32'(rsp_ng), 32'(yo[15]));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        if (rsp_ready) m_busy = 1'b0;
      end
    end
    if (req0_ready || req1_ready) begin
      g_id.push_back(req1_ready ? 1 : 0);
      g_cyc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      r_out_q.push_back(rsp_out);
      r_id_q.push_back(rsp_id);
      r_zr_q.push_back(rsp_zr);
      r_ng_q.push_back(rsp_ng);
      r_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic sync_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'd10,    16'd7, OP_AND,    16'd2,      1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'd10,    16'd7, OP_ADD,    16'd17,     1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'd10,    16'd7, OP_SUB_XY, 16'd3,      1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'd1234,  16'd9, OP_NEG1,   16'hFFFF,   1'b0, 1'b1};
    vecs[4] = '{1'b0, 16'd15,    16'd2, OP_ZERO,   16'd0,      1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'h7FFF,  16'd1, OP_ADD,    16'h8000,   1'b0, 1'b1};
    vecs[6] = '{1'b1, 16'hFFFF,  16'd1, OP_ADD,    16'd0,      1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'd5,     16'd3, 6'b000111, 16'hFFFE,   1'b0, 1'b1};

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_x = '0; req0_y = '0; req0_op = '0;
    req1_x = '0; req1_y = '0; req1_op = '0;
    model_reset();

    // Reset state: no readies even with both valid, response cleared
    @(posedge clk); @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out), 32'd0);
    chk("rst_rsp_flags", 32'({rsp_zr, rsp_ng, rsp_id}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors, one requester at a time
    foreach (vecs[i]) begin
      clear_logs();
      rsp_ready = 1'b1;
      if (vecs[i].rq) begin
        req1_valid = 1'b1; req1_x = vecs[i].x; req1_y = vecs[i].y; req1_op = vecs[i].op;
      end else begin
        req0_valid = 1'b1; req0_x = vecs[i].x; req0_y = vecs[i].y; req0_op = vecs[i].op;
      end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 6 && r_out_q.size() == 0; k++) step();
      chk("vec_rsp_seen", 32'(r_out_q.size()), 32'd1);
      if (r_out_q.size() > 0 && g_cyc.size() > 0) begin
        chk("vec_out", 32'(r_out_q[0]), 32'(vecs[i].eo));
        chk("vec_zr", 32'(r_zr_q[0]), 32'(vecs[i].ezr));
        chk("vec_ng", 32'(r_ng_q[0]), 32'(vecs[i].eng));
        chk("vec_id", 32'(r_id_q[0]), 32'(vecs[i].rq));
        chk("vec_latency", 32'(r_cyc_q[0] - g_cyc[0]), 32'd2);
      end
      step();
    end

    // Backpressure: NEG1 result held while rsp_ready low, nobody accepted
    clear_logs();
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_x = 16'h1234; req1_y = 16'h5678; req1_op = OP_NEG1;
    step();
    req0_valid = 1'b1; req0_x = 16'd15; req0_y = 16'd2; req0_op = OP_ZERO;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_out", 32'(rsp_out), 32'hFFFF);
      chk("bp_ng", 32'(rsp_ng), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    step();
    step();
    req0_valid = 1'b0;
    drain();
    chk("bp_rsp_count", 32'(r_out_q.size()), 32'd2);
    if (r_out_q.size() == 2) begin
      chk("bp_second_out", 32'(r_out_q[1]), 32'd0);
      chk("bp_second_zr", 32'(r_zr_q[1]), 32'd1);
    end

    // Both valid from reset: alternating grants at 3-cycle spacing
    sync_reset();
    clear_logs();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 16'd10; req0_y = 16'd7; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_x = 16'd10; req1_y = 16'd7; req1_op = OP_SUB_XY;
    for (int k = 0; k < 40 && g_id.size() < 8; k++) step();
    drain();
    chk("fair_grants", 32'(g_id.size()), 32'd8);
    if (g_id.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("fair_order", 32'(g_id[i]), 32'(i % 2));
      for (int i = 1; i < 8; i++) chk("fair_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    if (r_out_q.size() >= 2) begin
      chk("first_out", 32'(r_out_q[0]), 32'd17);
      chk("first_id", 32'(r_id_q[0]), 32'd0);
      chk("second_out", 32'(r_out_q[1]), 32'd3);
      chk("second_id", 32'(r_id_q[1]), 32'd1);
    end else begin
      chk("fair_rsp_count", 32'(r_out_q.size()), 32'd8);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_x = 16'($urandom); req0_y = 16'($urandom); req0_op = 6'($urandom);
      req1_x = 16'($urandom); req1_y = 16'($urandom); req1_op = 6'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset mid-EXEC: in-flight op discarded, outputs cleared
    clear_logs();
    req0_valid = 1'b1; req0_x = 16'd10; req0_y = 16'd7; req0_op = OP_ADD;
    step();
    chk("mid_accepted", 32'(g_id.size()), 32'd1);
    req1_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rsp_out", 32'(rsp_out), 32'd0);
    chk("mid_rsp_flags", 32'({rsp_zr, rsp_ng, rsp_id}), 32'd0);
    chk("mid_readies", 32'({req0_ready, req1_ready}), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) step();
    chk("mid_no_rsp", 32'(r_out_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
